// File: rtl/sent_tx_if.sv
// SENT transmitter frame/line bundle: frame offer handshake, payload and line-side status.
// master = frame source, slave = sent_tx_frame_gen.
interface sent_tx_if #(
    parameter int NUM_NIBBLES = 6
);
    logic                     enable;
    logic                     frame_valid;
    logic                     frame_ready;
    logic [3:0]               status_nib;
    logic [4*NUM_NIBBLES-1:0] frame_data;
    logic                     data_pulse;
    logic                     busy;
    logic                     frame_done;

    modport master (
        output enable, frame_valid, status_nib, frame_data,
        input  frame_ready, data_pulse, busy, frame_done
    );

    modport slave (
        input  enable, frame_valid, status_nib, frame_data,
        output frame_ready, data_pulse, busy, frame_done
    );
endinterface

// File: rtl/sent_tx_frame_gen.sv
// SENT (SAE J2716) frame generator: sync, status, data nibbles, CRC4, optional pause.
// Define SENT_TX_PAUSE_EN to append the pause pulse after the CRC nibble.
//
// state  | meaning
// IDLE   | line high, waiting for an accepted frame
// SYNC   | 56-tick calibration pulse
// STATUS | status/communication nibble pulse
// DATA   | data nibble pulses, most significant first
// CRC    | CRC4 nibble pulse
// PAUSE  | PAUSE_TICKS pulse (SENT_TX_PAUSE_EN builds only)
module sent_tx_frame_gen #(
    parameter int NUM_NIBBLES = 6,
    parameter int TICK_DIV    = 4,
    parameter int LOW_TICKS   = 5,
    parameter int PAUSE_TICKS = 20
) (
    input  logic      clk_tx,
    input  logic      reset_tx,
    sent_tx_if.slave  bus
);
    localparam int DW = 4 * NUM_NIBBLES;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NW = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
    localparam int PW = 10;

    if (NUM_NIBBLES < 1 || NUM_NIBBLES > 6) begin : g_bad_nibbles
        $error("NUM_NIBBLES out of range 1..6");
    end
    if (TICK_DIV < 1 || TICK_DIV > 1023) begin : g_bad_div
        $error("TICK_DIV out of range 1..1023");
    end
    if (LOW_TICKS < 4 || LOW_TICKS > 11) begin : g_bad_low
        $error("LOW_TICKS out of range 4..11");
    end
    if (PAUSE_TICKS < 12 || PAUSE_TICKS > 768) begin : g_bad_pause
        $error("PAUSE_TICKS out of range 12..768");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_STATUS, S_DATA, S_CRC
`ifdef SENT_TX_PAUSE_EN
        , S_PAUSE
`endif
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   tick_cnt;
    logic [PW-1:0]   pulse_cnt, pulse_cnt_nx, pulse_len;
    logic [NW-1:0]   nib_idx;
    logic [DW-1:0]   data_q;
    logic [3:0]      status_q;
    logic [3:0]      crc_q;
    logic            tick, pulse_end, accept, dp_nx;

    // Multiply by x^4 modulo x^4+x^3+x^2+1, i.e. one table step of the J2716 CRC.
    function automatic logic [3:0] crc_mulx4(input logic [3:0] c);
        logic [3:0] r;
        r = c;
        for (int b = 0; b < 4; b++) begin
            r = r[3] ? ({r[2:0], 1'b0} ^ 4'hD) : {r[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [3:0] crc_of(input logic [DW-1:0] d);
        logic [3:0] c;
        c = 4'h5;
        for (int k = NUM_NIBBLES - 1; k >= 0; k--) begin
            c = crc_mulx4(c) ^ d[4*k +: 4];
        end
        return crc_mulx4(c);
    endfunction

    assign accept    = bus.frame_valid & bus.frame_ready;
    assign tick      = (state != S_IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
    assign pulse_end = tick && (pulse_cnt == pulse_len - PW'(1));

    always_comb begin
        pulse_len = PW'(56);
        case (state)
            S_STATUS: pulse_len = PW'(12) + PW'(status_q);
            S_DATA:   pulse_len = PW'(12) + PW'(data_q[DW-1 -: 4]);
            S_CRC:    pulse_len = PW'(12) + PW'(crc_q);
`ifdef SENT_TX_PAUSE_EN
            S_PAUSE:  pulse_len = PW'(PAUSE_TICKS);
`endif
            default:  pulse_len = PW'(56);
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_SYNC;
            S_SYNC:   if (pulse_end) state_nx = S_STATUS;
            S_STATUS: if (pulse_end) state_nx = S_DATA;
            S_DATA:   if (pulse_end && nib_idx == NW'(NUM_NIBBLES - 1)) state_nx = S_CRC;
`ifdef SENT_TX_PAUSE_EN
            S_CRC:    if (pulse_end) state_nx = S_PAUSE;
            S_PAUSE:  if (pulse_end) state_nx = S_IDLE;
`else
            S_CRC:    if (pulse_end) state_nx = S_IDLE;
`endif
            default:  state_nx = S_IDLE;
        endcase

        pulse_cnt_nx = pulse_cnt;
        if (state == S_IDLE)  pulse_cnt_nx = '0;
        else if (pulse_end)   pulse_cnt_nx = '0;
        else if (tick)        pulse_cnt_nx = pulse_cnt + PW'(1);
    end

    always_comb begin
        bus.frame_ready = (state == S_IDLE) & bus.enable & ~reset_tx;
        bus.busy        = (state != S_IDLE);
`ifdef SENT_TX_PAUSE_EN
        bus.frame_done  = pulse_end & (state == S_PAUSE) & ~reset_tx;
`else
        bus.frame_done  = pulse_end & (state == S_CRC) & ~reset_tx;
`endif
        // Line level for the next cycle: low during the first LOW_TICKS ticks of each pulse.
        dp_nx = !((state_nx != S_IDLE) && (pulse_cnt_nx < PW'(LOW_TICKS)));
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            tick_cnt       <= '0;
            pulse_cnt      <= '0;
            nib_idx        <= '0;
            data_q         <= '0;
            status_q       <= '0;
            crc_q          <= 4'h5;
            bus.data_pulse <= 1'b1;
        end else begin
            bus.data_pulse <= dp_nx;
            pulse_cnt      <= pulse_cnt_nx;

            if (state == S_IDLE || tick) tick_cnt <= '0;
            else                         tick_cnt <= tick_cnt + TW'(1);

            if (state == S_IDLE)                   nib_idx <= '0;
            else if (state == S_DATA && pulse_end) nib_idx <= nib_idx + NW'(1);

            if (accept) begin
                data_q   <= bus.frame_data;
                status_q <= bus.status_nib;
                crc_q    <= crc_of(bus.frame_data);
            end else if (state == S_DATA && pulse_end) begin
                data_q   <= data_q << 4;
            end
        end
    end
endmodule

// File: tb/tb_sent_tx_frame_gen.sv
// Self-checking bench for sent_tx_frame_gen: J2716 table CRC model and tick-level line waveform.
module tb_sent_tx_frame_gen;
    localparam int NN          = 6;
    localparam int TICK_DIV    = 4;
    localparam int LOW_TICKS   = 5;
    localparam int PAUSE_TICKS = 20;

    logic clk_tx   = 1'b0;
    logic reset_tx = 1'b1;
    always #5 clk_tx = ~clk_tx;

    sent_tx_if #(.NUM_NIBBLES(NN)) sif ();

    sent_tx_frame_gen #(
        .NUM_NIBBLES(NN), .TICK_DIV(TICK_DIV), .LOW_TICKS(LOW_TICKS), .PAUSE_TICKS(PAUSE_TICKS)
    ) dut (
        .clk_tx  (clk_tx),
        .reset_tx(reset_tx),
        .bus     (sif)
    );

    int vectors = 0;
    int errors  = 0;
    bit exp_wave[$];
    int crc_tbl[16] = '{0, 13, 7, 10, 14, 3, 9, 4, 1, 12, 6, 11, 15, 2, 8, 5};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected line level per clk_tx cycle, from the frame's list of pulse lengths in ticks.
    function automatic void build_model(input logic [3:0] st, input logic [23:0] d);
        int lens[$];
        int c, nib;
        exp_wave.delete();
        lens.push_back(56);
        lens.push_back(12 + int'(st));
        c = 5;
        for (int k = 0; k < NN; k++) begin
            nib = int'((d >> (4 * (NN - 1 - k))) & 24'hF);
            lens.push_back(12 + nib);
            c = crc_tbl[c] ^ nib;
        end
        c = crc_tbl[c];
        lens.push_back(12 + c);
`ifdef SENT_TX_PAUSE_EN
        lens.push_back(PAUSE_TICKS);
`endif
        foreach (lens[p])
            for (int t = 0; t < lens[p]; t++)
                for (int q = 0; q < TICK_DIV; q++)
                    exp_wave.push_back(t >= LOW_TICKS);
    endfunction

    task automatic start_frame(input logic [3:0] st, input logic [23:0] d);
        @(negedge clk_tx);
        sif.status_nib  = st;
        sif.frame_data  = d;
        sif.frame_valid = 1'b1;
        check("ready_idle", sif.frame_ready, 1);
        @(negedge clk_tx);
        sif.frame_valid = 1'b0;
        sif.status_nib  = 4'($urandom);
        sif.frame_data  = 24'($urandom);
        build_model(st, d);
    endtask

    // Entered on the first SYNC cycle; leaves on the idle cycle after frame_done.
    task automatic check_frame(input string tag, output int done_at);
        int wave_err = 0, done_err = 0, busy_err = 0, n;
        done_at = 0;
        n = exp_wave.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk_tx);
            if (sif.data_pulse !== exp_wave[i]) wave_err++;
            if (sif.frame_done === 1'b1 && done_at == 0) done_at = i + 1;
            if (sif.frame_done !== (i == n - 1)) done_err++;
            if (sif.busy !== 1'b1) busy_err++;
        end
        check({tag, " wave_errs"}, wave_err, 0);
        check({tag, " done_errs"}, done_err, 0);
        check({tag, " busy_errs"}, busy_err, 0);
        @(negedge clk_tx);
        check({tag, " idle_busy"}, sif.busy, 0);
        check({tag, " idle_line"}, sif.data_pulse, 1);
    endtask

    initial begin
        int done_at, bad, fd_seen, offs;
        logic [3:0]  s1, s2;
        logic [23:0] d1, d2;

        sif.enable      = 1'b1;
        sif.frame_valid = 1'b1;
        sif.status_nib  = 4'h0;
        sif.frame_data  = 24'h000000;

        // Reset held with a frame on offer: nothing may start.
        repeat (3) begin
            @(negedge clk_tx);
            check("rst_ready", sif.frame_ready, 0);
            check("rst_line", sif.data_pulse, 1);
            check("rst_busy", sif.busy, 0);
        end
        reset_tx = 1'b0;
        check("rst_rel_busy", sif.busy, 0);
        build_model(4'h0, 24'h000000);
        @(negedge clk_tx);
        sif.frame_valid = 1'b0;
        check_frame("zero", done_at);
`ifdef SENT_TX_PAUSE_EN
        check("zero_len", done_at, 177 * TICK_DIV);
`else
        check("zero_len", done_at, 157 * TICK_DIV);
`endif

        start_frame(4'($urandom), 24'hFFFFFF);
        check_frame("all_f", done_at);

        for (int r = 0; r < 4; r++) begin
            start_frame(4'($urandom), 24'($urandom));
            check_frame("rand", done_at);
        end

        // Back-to-back with frame_valid held high through the first frame.
        s1 = 4'($urandom); d1 = 24'($urandom);
        s2 = 4'($urandom); d2 = 24'($urandom);
        @(negedge clk_tx);
        sif.status_nib = s1; sif.frame_data = d1; sif.frame_valid = 1'b1;
        @(negedge clk_tx);
        sif.status_nib = s2; sif.frame_data = d2;
        build_model(s1, d1);
        check_frame("b2b_1", done_at);
        check("b2b_ready", sif.frame_ready, 1);
        @(negedge clk_tx);
        sif.frame_valid = 1'b0;
        build_model(s2, d2);
        check_frame("b2b_2", done_at);

        // enable dropped mid-frame: frame completes, then no new start.
        start_frame(4'($urandom), 24'($urandom));
        sif.enable = 1'b0;
        check_frame("en_drop", done_at);
        sif.frame_valid = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk_tx);
            if (sif.busy !== 1'b0 || sif.frame_ready !== 1'b0) bad++;
        end
        check("en_off_hold", bad, 0);
        sif.frame_valid = 1'b0;
        sif.enable      = 1'b1;

        // Reset two ticks into the third data nibble.
        s1 = 4'($urandom); d1 = 24'($urandom);
        start_frame(s1, d1);
        offs = (56 + 12 + int'(s1) + 12 + int'(d1[23:20]) + 12 + int'(d1[19:16]) + 2) * TICK_DIV;
        fd_seen = 0;
        for (int i = 0; i < offs; i++) begin
            @(negedge clk_tx);
            if (sif.frame_done === 1'b1) fd_seen++;
        end
        reset_tx = 1'b1;
        if (sif.frame_done === 1'b1) fd_seen++;
        @(negedge clk_tx);
        check("abort_line", sif.data_pulse, 1);
        check("abort_busy", sif.busy, 0);
        check("abort_done", fd_seen + int'(sif.frame_done === 1'b1), 0);
        reset_tx = 1'b0;
        start_frame(4'($urandom), 24'($urandom));
        check_frame("post_abort", done_at);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
